// File: rtl/down_counter_timer.sv
// Loadable down-counting timer: counts a programmed value to zero, one-shot or auto-reload.
// Flags terminal count with a one-cycle tc pulse; busy/done reflect the RUN/DONE states.
module down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;

    // State, count, reload and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count    <= ZERO;
            reload_q <= ZERO;
            tc       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            reload_q <= reload_d;
            tc       <= tc_d;
            busy     <= (state_d == RUN);
            done     <= (state_d == DONE);
        end
    end

    // Next-state and datapath; load beats stop beats start
    always_comb begin
        state_d  = state_q;
        count_d  = count;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stop && start && (count != ZERO)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (count > ONE) begin
                        count_d = count - ONE;
                    end else if (count == ONE) begin
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = ZERO;
                            state_d = DONE;
                        end
                    end else begin
                        // Zero in RUN is unreachable; park in DONE quietly
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (!stop && start && (reload_q != ZERO)) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable, parameterised down-counting timer; the count-down counterpart of the team's loadable 4-bit up counter.
- Counts a programmed value down to zero and flags terminal count.
- Runs as a one-shot or auto-reload periodic timer.
- Used as a programmable delay or tick generator alongside the up counter in the counter library.

Parameters:
- WIDTH, 4, bit width of count, load_val and the internal reload register.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  load request; copies load_val into count and the reload register
- load_val  input  WIDTH  value to load / reload period
- start  input  1  start or resume counting
- stop  input  1  pause counting; count holds
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled every RUN cycle
- count  output  WIDTH  current counter value, registered
- tc  output  1  terminal-count pulse, registered, one cycle wide
- busy  output  1  high while in RUN
- done  output  1  high while in DONE (one-shot expired)

Behaviour:
- One clock domain. Reset is synchronous and active-high, on ports clk and rst.
- Reset (rst=1 at an edge):
  - count=0, reload register=0, tc=0.
  - State goes to IDLE, so busy=0 and done=0.
  - Reset overrides every other input, in any state, including mid-run.
- Input priority at each edge: rst > load > stop > start.
- States: IDLE, RUN, DONE. Encode as registered state; busy = (state==RUN), done = (state==DONE).
- tc defaults to 0 every cycle unless set by the RUN rule below.
- load=1, any state:
  - count<=load_val and reload<=load_val.
  - State goes to IDLE; done and busy clear at the same edge.
  - A start in the same cycle is ignored.
- IDLE:
  - start=1 with count!=0: go to RUN; count holds this edge.
  - start=1 with count==0: ignored, stay in IDLE.
- RUN, stop=1: go to IDLE; count holds. A later start resumes from the held value.
- RUN, stop=0:
  - count>1: count<=count-1.
  - count==1: tc<=1.
    - auto_reload=1: count<=reload, stay in RUN.
    - auto_reload=0: count<=0, go to DONE.
  - count==0 cannot occur in RUN; if it does (e.g. after an X-fix), go to DONE without a tc pulse.
- DONE:
  - count holds 0.
  - start=1 with reload!=0: count<=reload, go to RUN.
  - start=1 with reload==0: ignored.
- Latency and periods:
  - One-shot from value N: tc and done rise N+1 edges after the start edge. The +1 is the start edge, which does not decrement.
  - Auto-reload: tc pulses every N cycles; count sequence is N..1, N..1, ...
- Width rules: arithmetic is unsigned modulo 2^WIDTH. Max load is 2^WIDTH-1, e.g. 15 for WIDTH=4.
- Decrement never wraps below 0; reload occurs at 1 instead.
- Changing auto_reload mid-run takes effect at the next count==1 decision.
- stop and start in the same cycle: stop wins.

Test Plan:
- Reset: assert rst 2 cycles from random state -> count=0, tc=0, busy=0, done=0. Then start with no load -> remains IDLE, count=0.
- One-shot: load_val=5, load 1 cycle, start 1 cycle, auto_reload=0 -> busy=1; count 5,4,3,2,1,0 on successive edges. tc=1 exactly on the edge count becomes 0; done=1 and busy=0 on that edge; count stays 0 thereafter.
- Auto-reload: load_val=3, auto_reload=1, start -> count 3,2,1,3,2,1,3... tc pulses once every 3 cycles, on the 1->3 transitions; done stays 0 for 12 cycles.
- Pause/resume: load 6, start, assert stop when count=4 for 4 cycles -> count holds 4, busy=0. Start -> 3,2,1,0, tc, done.
- Priority/collisions:
  - load=1 with start=1 (load_val=9) -> count=9, state IDLE.
  - During RUN, load 2 -> count=2, busy=0.
  - stop=1 with start=1 in RUN -> IDLE.
- Restart and reset mid-run:
  - From DONE after load 4, start -> count reloads 4 and runs to tc.
  - rst asserted when count=2 in RUN -> next edge count=0, busy=0, tc=0. Reload cleared, so start from DONE is impossible until the next load.
- WIDTH=8 variant: load 255 one-shot -> tc after 256 edges from start; no wrap to 255.
